// File: rtl/io_baud_tick_generator_if.sv
// Control/status bundle for io_baud_tick_generator.
//   enable          - counting enable; low pauses and holds phase
//   restart         - one-cycle phase restart (start-bit alignment)
//   divisor_wr      - strobe capturing divisor_in as the pending divisor
//   divisor_in      - new clocks-per-sample value (0 is treated as 1)
//   sample_tick     - one-cycle pulse every divisor clocks
//   mid_tick        - pulse on sample index OVERSAMPLE/2-1 of each bit
//   bit_tick        - pulse on sample index OVERSAMPLE-1 (end of bit)
//   divisor_out     - currently active divisor
//   divisor_pending - a written divisor is waiting for a bit boundary
// master = controller side, slave = generator side.
interface io_baud_tick_generator_if #(
  parameter int DIV_WIDTH = 16
);
  logic                 enable;
  logic                 restart;
  logic                 divisor_wr;
  logic [DIV_WIDTH-1:0] divisor_in;
  logic                 sample_tick;
  logic                 mid_tick;
  logic                 bit_tick;
  logic [DIV_WIDTH-1:0] divisor_out;
  logic                 divisor_pending;

  modport master (
    output enable, restart, divisor_wr, divisor_in,
    input  sample_tick, mid_tick, bit_tick, divisor_out, divisor_pending
  );

  modport slave (
    input  enable, restart, divisor_wr, divisor_in,
    output sample_tick, mid_tick, bit_tick, divisor_out, divisor_pending
  );
endinterface

// File: rtl/io_baud_tick_generator.sv
// Oversampling baud tick generator for the UART I/O path.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - io_baud_tick_generator_if.slave (controls, ticks, divisor status)
// A clock counter divides clk by the active divisor to make sample_tick; a
// sample index counts OVERSAMPLE samples per bit to place mid_tick and
// bit_tick. Divisor writes are parked until the next bit boundary (or a
// restart) so an in-flight bit is never stretched or shortened.
module io_baud_tick_generator #(
  parameter int CLOCK_FREQ      = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int OVERSAMPLE      = 16,
  parameter int DIV_WIDTH       = 16,
  parameter int DEFAULT_DIVISOR = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
  input  logic                     clk,
  input  logic                     reset,
  io_baud_tick_generator_if.slave  bus
);

  localparam int IDX_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
  // Effective divisor is never below 1, including the reset value.
  localparam logic [DIV_WIDTH-1:0] RST_DIV =
    (DEFAULT_DIVISOR < 1) ? DIV_WIDTH'(1) : DIV_WIDTH'(DEFAULT_DIVISOR);

  logic [DIV_WIDTH-1:0] cnt;
  logic [IDX_W-1:0]     idx;
  logic [DIV_WIDTH-1:0] div;
  logic [DIV_WIDTH-1:0] pend;
  logic                 pend_vld;
  logic                 sample_q, mid_q, bit_q;

  logic                 cnt_wrap;
  logic                 bit_edge;
  logic                 apply;
  logic [DIV_WIDTH-1:0] wr_val;

  assign cnt_wrap = bus.enable && !bus.restart && (cnt == div - DIV_WIDTH'(1));
  assign bit_edge = cnt_wrap && (idx == IDX_LAST);
  // Divisor changes only at a bit boundary or a phase restart.
  assign apply    = bus.restart || bit_edge;
  assign wr_val   = (bus.divisor_in == '0) ? DIV_WIDTH'(1) : bus.divisor_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      idx      <= '0;
      div      <= RST_DIV;
      pend     <= RST_DIV;
      pend_vld <= 1'b0;
      sample_q <= 1'b0;
      mid_q    <= 1'b0;
      bit_q    <= 1'b0;
    end else begin
      sample_q <= 1'b0;
      mid_q    <= 1'b0;
      bit_q    <= 1'b0;

      if (bus.restart) begin
        cnt <= '0;
        idx <= '0;
      end else if (bus.enable) begin
        if (cnt_wrap) begin
          cnt      <= '0;
          sample_q <= 1'b1;
          mid_q    <= (idx == IDX_MID);
          bit_q    <= (idx == IDX_LAST);
          idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
          cnt <= cnt + DIV_WIDTH'(1);
        end
      end

      // A write landing on the applying edge wins over the parked value.
      if (apply) begin
        if (bus.divisor_wr)  div <= wr_val;
        else if (pend_vld)   div <= pend;
        pend_vld <= 1'b0;
      end else if (bus.divisor_wr) begin
        pend     <= wr_val;
        pend_vld <= 1'b1;
      end
    end
  end

  assign bus.sample_tick     = sample_q;
  assign bus.mid_tick        = mid_q;
  assign bus.bit_tick        = bit_q;
  assign bus.divisor_out     = div;
  assign bus.divisor_pending = pend_vld;

endmodule

// File: tb/tb_io_baud_tick_generator.sv
module tb_io_baud_tick_generator;

  localparam int DW   = 16;
  localparam int NCYC = 130;

  logic clk = 1'b0;
  logic reset;

  io_baud_tick_generator_if #(.DIV_WIDTH(DW)) bus();

  io_baud_tick_generator #(
    .CLOCK_FREQ(1600), .BAUD_RATE(25), .OVERSAMPLE(16), .DIV_WIDTH(DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          scn;
    int          cyc;
    logic        st;
    logic        mt;
    logic        bt;
    logic [DW-1:0] dout;
    logic        pend;
  } vec_t;

  vec_t vecs[$];
  logic [DW+3:0] rec [0:NCYC];
  int n_total = 0;
  int n_pass  = 0;

  function automatic logic [DW+3:0] pack(logic st, logic mt, logic bt,
                                         logic pend, logic [DW-1:0] dout);
    return {st, mt, bt, pend, dout};
  endfunction

  function automatic logic [DW+3:0] snap();
    return pack(bus.sample_tick, bus.mid_tick, bus.bit_tick,
                bus.divisor_pending, bus.divisor_out);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input int s, input int c, input logic st, input logic mt,
                     input logic bt, input int dout, input logic pend);
    vec_t v;
    v.scn = s; v.cyc = c; v.st = st; v.mt = mt; v.bt = bt;
    v.dout = DW'(dout); v.pend = pend;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.enable = 1'b0; bus.restart = 1'b0;
    bus.divisor_wr = 1'b0; bus.divisor_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Inputs seen by rising edge n after reset release, per scenario.
  task automatic drive(input int s, input int n);
    bus.enable = 1'b1; bus.restart = 1'b0;
    bus.divisor_wr = 1'b0; bus.divisor_in = '0;
    case (s)
      1: if (n == 21) begin bus.divisor_wr = 1'b1; bus.divisor_in = 16'd3; end
         else if (n == 30) begin bus.divisor_wr = 1'b1; bus.divisor_in = 16'd2; end
      2: if (n == 10) bus.restart = 1'b1;
      3: if (n >= 2 && n <= 6) bus.enable = 1'b0;
      4: if (n == 1) begin bus.divisor_wr = 1'b1; bus.divisor_in = 16'd0; end
         else if (n == 2) bus.restart = 1'b1;
      5: if (n == 5) begin bus.restart = 1'b1; bus.divisor_wr = 1'b1; bus.divisor_in = 16'd2; end
      6: if (n == 64) begin bus.divisor_wr = 1'b1; bus.divisor_in = 16'd3; end
      default: ;
    endcase
  endtask

  task automatic run_scn(input int s);
    do_reset();
    rec[0] = snap();
    for (int n = 1; n <= NCYC; n++) begin
      drive(s, n);
      @(posedge clk);
      #1;
      rec[n] = snap();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.restart = 1'b0;
    bus.divisor_wr = 1'b0; bus.divisor_in = '0;

    // scn, cycle, sample, mid, bit, divisor_out, pending
    add(0,   0, 0, 0, 0, 4, 0);
    add(0,   3, 0, 0, 0, 4, 0);
    add(0,   4, 1, 0, 0, 4, 0);
    add(0,   8, 1, 0, 0, 4, 0);
    add(0,  12, 1, 0, 0, 4, 0);
    add(0,  31, 0, 0, 0, 4, 0);
    add(0,  32, 1, 1, 0, 4, 0);
    add(0,  64, 1, 0, 1, 4, 0);
    add(0,  65, 0, 0, 0, 4, 0);
    add(0, 128, 1, 0, 1, 4, 0);
    add(1,  21, 0, 0, 0, 4, 1);
    add(1,  60, 1, 0, 0, 4, 1);
    add(1,  63, 0, 0, 0, 4, 1);
    add(1,  64, 1, 0, 1, 2, 0);
    add(1,  65, 0, 0, 0, 2, 0);
    add(1,  66, 1, 0, 0, 2, 0);
    add(1,  68, 1, 0, 0, 2, 0);
    add(1,  96, 1, 0, 1, 2, 0);
    add(2,  12, 0, 0, 0, 4, 0);
    add(2,  14, 1, 0, 0, 4, 0);
    add(2,  42, 1, 1, 0, 4, 0);
    add(2,  74, 1, 0, 1, 4, 0);
    add(3,   4, 0, 0, 0, 4, 0);
    add(3,   8, 0, 0, 0, 4, 0);
    add(3,   9, 1, 0, 0, 4, 0);
    add(3,  69, 1, 0, 1, 4, 0);
    add(4,   1, 0, 0, 0, 4, 1);
    add(4,   2, 0, 0, 0, 1, 0);
    add(4,   3, 1, 0, 0, 1, 0);
    add(4,   4, 1, 0, 0, 1, 0);
    add(4,  10, 1, 1, 0, 1, 0);
    add(4,  18, 1, 0, 1, 1, 0);
    add(4,  26, 1, 1, 0, 1, 0);
    add(4,  34, 1, 0, 1, 1, 0);
    add(5,   5, 0, 0, 0, 2, 0);
    add(5,   6, 0, 0, 0, 2, 0);
    add(5,   7, 1, 0, 0, 2, 0);
    add(6,  64, 1, 0, 1, 3, 0);
    add(6,  66, 0, 0, 0, 3, 0);
    add(6,  67, 1, 0, 0, 3, 0);
    add(6, 112, 1, 0, 1, 3, 0);

    for (int s = 0; s <= 6; s++) begin
      run_scn(s);
      foreach (vecs[i]) begin
        if (vecs[i].scn == s) begin
          chk($sformatf("scn%0d_cyc%0d", s, vecs[i].cyc),
              32'(rec[vecs[i].cyc]),
              32'(pack(vecs[i].st, vecs[i].mt, vecs[i].bt, vecs[i].pend, vecs[i].dout)));
        end
      end
    end

    // Asynchronous reset in the middle of a bit running at divisor 1.
    do_reset();
    for (int n = 1; n <= 30; n++) begin
      drive(4, n);
      @(posedge clk);
      #1;
    end
    chk("pre_reset_tick", 32'(bus.sample_tick), 32'd1);
    chk("pre_reset_div", 32'(bus.divisor_out), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_ticks", 32'({bus.sample_tick, bus.mid_tick, bus.bit_tick}), 32'd0);
    chk("async_reset_div", 32'(bus.divisor_out), 32'd4);
    chk("async_reset_pend", 32'(bus.divisor_pending), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.enable = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      #1;
      if (n == 3) chk("post_reset_cyc3", 32'(bus.sample_tick), 32'd0);
      if (n == 4) chk("post_reset_cyc4", 32'(bus.sample_tick), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/io_baud_tick_generator.md
# io_baud_tick_generator

Programmable, oversampling baud tick generator for the UART I/O path. It produces a sample-rate tick, a mid-bit tick and a bit-boundary tick from one clock. The divisor can be changed at runtime without glitching an in-flight bit. A phase restart lets the RX side align bit timing to a detected start-bit edge.

## Interface
Parameters:
- CLOCK_FREQ, 100000000: clock frequency in Hz.
- BAUD_RATE, 115200: baud rate used to compute the reset divisor.
- OVERSAMPLE, 16: sample ticks per bit. Must be even and ≥2.
- DIV_WIDTH, 16: width of the divisor register.
- DEFAULT_DIVISOR, CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE): clocks per sample tick after reset. Integer division; evaluates to 54 with the defaults.

Ports:
- clk  in  1  system clock. Everything is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  counting enable. When low, the generator pauses and holds its phase.
- restart  in  1  single-cycle request to restart the phase at the start of a bit.
- divisor_wr  in  1  write strobe for divisor_in.
- divisor_in  in  DIV_WIDTH  new clocks-per-sample value.
- sample_tick  out  1  one-cycle pulse every divisor clocks.
- mid_tick  out  1  one-cycle pulse on sample index OVERSAMPLE/2-1 of each bit.
- bit_tick  out  1  one-cycle pulse on sample index OVERSAMPLE-1, which is the end of the bit.
- divisor_out  out  DIV_WIDTH  currently active divisor.
- divisor_pending  out  1  high while a written divisor is waiting for a bit boundary.

## Operation
- State:
  - clock counter `cnt` (DIV_WIDTH bits)
  - sample index `idx` (clog2(OVERSAMPLE) bits)
  - active divisor `div`
  - pending divisor register with a valid flag
- Reset values:
  - cnt=0, idx=0, div=DEFAULT_DIVISOR, pending invalid.
  - All tick outputs 0; divisor_out=DEFAULT_DIVISOR; divisor_pending=0.
- Divisor value 0 is written as 1. Effective divisor is always ≥1.
- Each edge with enable=1 and restart=0:
  - If cnt==div-1: cnt←0, sample_tick←1, idx←idx+1 (wraps to 0 after OVERSAMPLE-1).
  - Otherwise: cnt←cnt+1, sample_tick←0.
- mid_tick and bit_tick are registered in the same edge as sample_tick. Each is set only when sample_tick is set and the pre-increment idx matches its index.
- enable=0: cnt, idx and div hold; all ticks are 0 the next cycle. restart and divisor_wr are still honoured.
- restart=1 (has priority over counting):
  - cnt←0, idx←0, all ticks←0.
  - Any pending divisor is applied immediately.
- divisor_wr=1: captures divisor_in into pending and sets divisor_pending.
  - Pending is applied at the edge that asserts bit_tick, or at restart. The new value governs the next bit.
  - A second write before application overwrites the pending value.
- Simultaneous events:
  - divisor_wr with restart: the written value becomes active immediately.
  - divisor_wr on the bit_tick edge: the written value is applied at that boundary.

## Timing
- Cycle n means the cycle after the n-th rising edge following reset deassert with enable=1.
- First sample_tick is high in cycle div; thereafter every div cycles.
- A bit lasts div*OVERSAMPLE cycles. mid_tick falls in cycle div*OVERSAMPLE/2; bit_tick falls in cycle div*OVERSAMPLE.
- restart sampled at edge k: first sample_tick is in cycle k+div.
- Each cycle enable is low delays every subsequent tick by one cycle.
- divisor_out reflects the new value in the cycle after the edge that applies it.
- divisor_pending clears in the same cycle that divisor_out changes.
- Asserting reset mid-bit clears state immediately and asynchronously; ticks go low without waiting for an edge.

## Test plan
Bench parameters: CLOCK_FREQ=1600, BAUD_RATE=25, OVERSAMPLE=16, which gives div=4.
- Reset release, enable=1 -> sample_tick in cycles 4, 8, 12…; mid_tick in cycle 32; bit_tick in cycles 64 and 128; divisor_out=4.
- Write 2 in cycle 20 -> divisor_pending=1 until cycle 64; ticks still every 4 until cycle 64, then sample_tick at 66, 68…; next bit_tick at cycle 96.
- restart in cycle 10 -> no tick in cycle 12; sample_tick at 14; mid_tick at 42; bit_tick at 74.
- enable low for 5 cycles from cycle 2 -> first sample_tick at cycle 9; bit_tick at 69.
- Write 0, then restart -> divisor_out=1; sample_tick every cycle; mid_tick and bit_tick every 16 cycles, 8 cycles apart.
- Assert reset in cycle 30 -> ticks 0 immediately; divisor_out returns to 4; timing restarts from cycle 0.
